pcs_sync_ctrl: RTL and testbench
================================

Name: pcs_sync_ctrl

Overview:
- 1000BASE-X receive synchronisation controller that sits between the SerDes parallel output and the 8b/10b decoder.
- Aligns the raw 10-bit stream to code-group boundaries using comma detection, then presents aligned code groups to the decoder.
- Runs the code-group sync state machine using the decoder's invalid flag, and drives sync_status and rx_even to the downstream receive logic.

Parameters:
COMMAS_TO_SYNC, 3, consecutive even-slot commas needed to declare sync (range 1..7)
ERRS_TO_LOSE, 4, error level at which sync is lost (range 1..7)
GOOD_TO_RECOVER, 4, consecutive good code groups that decrement the error level by one (range 1..15)

Ports:
clk  in  1  receive clock
reset  in  1  asynchronous, active-high reset
rx_raw  in  10  raw SerDes word; bit 9 is the first bit received
rx_raw_valid  in  1  rx_raw is valid this cycle
cg_out  out  10  aligned code group, to the decoder's data_10b
cg_valid  out  1  cg_out is valid this cycle
cg_invalid  in  1  decoder flag for cg_out (combinational, same cycle)
comma_det  out  1  cg_out carries a comma; combinational from cg_out, qualified by cg_valid
rx_even  out  1  cg_out occupies an even slot
sync_status  out  1  1 = code-group sync acquired
align_offset  out  4  locked bit offset, 0..9

Behaviour:
- Reset: all outputs 0; prev_raw=0; state=LOSS_OF_SYNC; all counters 0.
- Comma definition: bits [9:3] of a 10-bit group equal 7'b0011111 or 7'b1100000.
- Window: W = {prev_raw, rx_raw}. Candidate k (k=0..9) is W[19-k -: 10].
- Per valid beat (rx_raw_valid=1), at the clock edge:
  - prev_raw <= rx_raw.
  - cg_out <= candidate at the offset in force (next_offset); cg_valid <= 1.
- cg_valid=0 in any cycle without a valid beat; the FSM holds in those cycles.
- Latency: 1 clk from the beat to cg_out.
- Offset search: only in LOSS_OF_SYNC. If any candidate is a comma, next_offset = lowest such k and align_offset <= k. With no comma, offset is held.
- In COMMA_DET and SYNC, offset is frozen; commas at other offsets are ignored.
- Slot tracking, evaluated when cg_valid=1:
  - A comma sets rx_even <= 0 for the next group (the comma itself is even).
  - Any other group toggles rx_even.
  - The rx_even output shows the slot of the current cg_out.
- bad_cg = cg_invalid OR (comma_det AND rx_even==0). good_cg = NOT bad_cg.
- FSM (advances only when cg_valid=1; sync_status updates the cycle after the transition):
  - LOSS_OF_SYNC: sync_status=0. On comma_det: go to COMMA_DET, comma_cnt=1, rx_even treated as even.
  - COMMA_DET:
    - bad_cg -> LOSS_OF_SYNC.
    - good comma -> comma_cnt+1; when it reaches COMMAS_TO_SYNC -> SYNC with err_lvl=0, good_cnt=0.
    - good non-comma -> stay.
  - SYNC: sync_status=1.
    - bad_cg -> err_lvl+1 and good_cnt=0. If err_lvl reaches ERRS_TO_LOSE -> LOSS_OF_SYNC.
    - good_cg with err_lvl>0 -> good_cnt+1. When good_cnt reaches GOOD_TO_RECOVER: err_lvl-1, good_cnt=0.
    - good_cg with err_lvl=0 -> no change.
- Simultaneous: a bad_cg that is also a comma counts as bad only.
- Reset asserted mid-operation -> immediate return to reset values; no output glitch is held beyond the reset.

Optional Feature:
- Macro PCS_SYNC_STATS_EN.
- Defined: adds output port sync_loss_cnt[15:0], a saturating count (stops at 16'hFFFF) of SYNC->LOSS_OF_SYNC transitions. Reset value 0.
- Undefined: port and logic absent; all other behaviour identical.

Test Plan:
- K28.5 (0011111010) then D16.2 (1001000101), repeated, at offset 0 -> align_offset=0. sync_status=1 one cycle after the 3rd comma reaches cg_out, with cg_out matching the input 1 clk after each beat.
- Same stream shifted by 3 bits -> align_offset=3; cg_out equals the unshifted code groups; sync acquired after 3 commas.
- Two consecutive commas (second lands on odd slot) during COMMA_DET -> bad_cg, state returns to LOSS_OF_SYNC, sync_status stays 0.
- In SYNC, force cg_invalid=1 for 3 groups, then 8 good groups, then 4 invalid -> sync_status stays 1 (err_lvl 3 -> 1), then drops to 0 on the 4th invalid (err_lvl 1+3 = 4).
- Inject 4 consecutive invalid groups in SYNC -> sync_status=0 the cycle after the 4th. With PCS_SYNC_STATS_EN, sync_loss_cnt increments 0->1.
- Assert reset while in SYNC with rx_raw_valid gaps -> all outputs 0 immediately; re-sync requires 3 fresh commas.

Source files
------------

// File: rtl/pcs_sync_ctrl.sv
// pcs_sync_ctrl: 1000BASE-X receive code-group alignment and sync controller.
// Sits between the SerDes parallel word and the 8b/10b decoder: finds the comma
// boundary, presents aligned code groups, and runs the code-group sync FSM from
// the decoder's invalid flag.
// Optional build macro PCS_SYNC_STATS_EN adds sync_loss_cnt, a saturating count
// of SYNC -> LOSS_OF_SYNC transitions.
//
// Handshake: rx_raw is consumed on every clock where rx_raw_valid=1 (no
// back-pressure). The aligned group appears on cg_out one clock later with
// cg_valid=1; cg_invalid must be a same-cycle function of cg_out while cg_valid=1.
module pcs_sync_ctrl #(
  parameter int COMMAS_TO_SYNC  = 3,
  parameter int ERRS_TO_LOSE    = 4,
  parameter int GOOD_TO_RECOVER = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [9:0]  rx_raw,
  input  logic        rx_raw_valid,
  output logic [9:0]  cg_out,
  output logic        cg_valid,
  input  logic        cg_invalid,
  output logic        comma_det,
  output logic        rx_even,
  output logic        sync_status,
  output logic [3:0]  align_offset
`ifdef PCS_SYNC_STATS_EN
  ,
  output logic [15:0] sync_loss_cnt
`endif
);

  typedef enum logic [1:0] {
    ST_LOSS_OF_SYNC = 2'd0,
    ST_COMMA_DET    = 2'd1,
    ST_SYNC         = 2'd2
  } state_t;

  localparam logic [2:0] COMMAS_LIM = 3'(COMMAS_TO_SYNC);
  localparam logic [2:0] ERRS_LIM   = 3'(ERRS_TO_LOSE);
  localparam logic [3:0] GOOD_LIM   = 4'(GOOD_TO_RECOVER);

  // A comma is identified by the top seven bits of a code group.
  function automatic logic is_comma(input logic [6:0] hi);
    return (hi == 7'b0011111) || (hi == 7'b1100000);
  endfunction

  logic [9:0]  prev_raw;
  logic [19:0] window;
  logic [19:0] shifted;
  logic        search_hit;
  logic [3:0]  search_k;
  logic [3:0]  next_offset;
  logic [9:0]  aligned;

  state_t      state_q, state_d;
  logic [2:0]  comma_cnt_q, comma_cnt_d;
  logic [2:0]  err_lvl_q, err_lvl_d;
  logic [3:0]  good_cnt_q, good_cnt_d;
  logic        bad_cg;

  // Comma search over all ten bit offsets; the lowest matching offset wins.
  always_comb begin
    window     = {prev_raw, rx_raw};
    search_hit = 1'b0;
    search_k   = 4'd0;
    for (int k = 9; k >= 0; k--) begin
      if (is_comma(window[19-k -: 7])) begin
        search_hit = 1'b1;
        search_k   = 4'(k);
      end
    end
    // The offset only moves while hunting; once a comma is seen it is frozen.
    if (state_q == ST_LOSS_OF_SYNC && search_hit) begin
      next_offset = search_k;
    end else begin
      next_offset = align_offset;
    end
    shifted = window << next_offset;
    aligned = shifted[19:10];
  end

  assign comma_det = cg_valid & is_comma(cg_out[9:3]);
  // A comma on an odd slot is a framing error; an invalid comma counts as bad only.
  assign bad_cg    = cg_invalid | (comma_det & ~rx_even);

  // Datapath: capture the beat, emit the aligned group and track slot parity.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev_raw     <= '0;
      cg_out       <= '0;
      cg_valid     <= 1'b0;
      align_offset <= '0;
      rx_even      <= 1'b0;
    end else begin
      cg_valid <= rx_raw_valid;
      if (rx_raw_valid) begin
        prev_raw     <= rx_raw;
        cg_out       <= aligned;
        align_offset <= next_offset;
      end
      if (cg_valid) begin
        rx_even <= comma_det ? 1'b0 : ~rx_even;
      end
    end
  end

  // Sync FSM next-state: evaluated only for groups actually on cg_out.
  always_comb begin
    state_d     = state_q;
    comma_cnt_d = comma_cnt_q;
    err_lvl_d   = err_lvl_q;
    good_cnt_d  = good_cnt_q;
    if (cg_valid) begin
      case (state_q)
        ST_LOSS_OF_SYNC: begin
          if (comma_det && !cg_invalid) begin
            comma_cnt_d = 3'd1;
            if (COMMAS_LIM == 3'd1) begin
              state_d    = ST_SYNC;
              err_lvl_d  = 3'd0;
              good_cnt_d = 4'd0;
            end else begin
              state_d = ST_COMMA_DET;
            end
          end
        end
        ST_COMMA_DET: begin
          if (bad_cg) begin
            state_d = ST_LOSS_OF_SYNC;
          end else if (comma_det) begin
            comma_cnt_d = comma_cnt_q + 3'd1;
            if (comma_cnt_d == COMMAS_LIM) begin
              state_d    = ST_SYNC;
              err_lvl_d  = 3'd0;
              good_cnt_d = 4'd0;
            end
          end
        end
        ST_SYNC: begin
          if (bad_cg) begin
            err_lvl_d  = err_lvl_q + 3'd1;
            good_cnt_d = 4'd0;
            if (err_lvl_d == ERRS_LIM) begin
              state_d = ST_LOSS_OF_SYNC;
            end
          end else if (err_lvl_q != 3'd0) begin
            good_cnt_d = good_cnt_q + 4'd1;
            if (good_cnt_d == GOOD_LIM) begin
              err_lvl_d  = err_lvl_q - 3'd1;
              good_cnt_d = 4'd0;
            end
          end
        end
        default: begin
          state_d = ST_LOSS_OF_SYNC;
        end
      endcase
    end
  end

  // Sync FSM state and counters; sync_status follows the state just entered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_LOSS_OF_SYNC;
      comma_cnt_q <= '0;
      err_lvl_q   <= '0;
      good_cnt_q  <= '0;
      sync_status <= 1'b0;
    end else begin
      state_q     <= state_d;
      comma_cnt_q <= comma_cnt_d;
      err_lvl_q   <= err_lvl_d;
      good_cnt_q  <= good_cnt_d;
      sync_status <= (state_d == ST_SYNC);
    end
  end

`ifdef PCS_SYNC_STATS_EN
  // Saturating count of lost-sync events.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_loss_cnt <= '0;
    end else if (state_q == ST_SYNC && state_d == ST_LOSS_OF_SYNC &&
                 sync_loss_cnt != 16'hFFFF) begin
      sync_loss_cnt <= sync_loss_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pcs_sync_ctrl.sv
// tb_pcs_sync_ctrl: randomized stimulus for pcs_sync_ctrl with a behavioural
// reference model; expected groups are queued at stimulus time and a monitor
// compares them whenever cg_valid is presented.
module tb_pcs_sync_ctrl;

  localparam int C2S = 3;
  localparam int E2L = 4;
  localparam int G2R = 4;
  localparam logic [9:0] K285 = 10'b0011111010;
  localparam logic [9:0] D162 = 10'b1001000101;

  // ---------------- clock / reset / DUT ----------------
  logic        clk = 1'b0;
  logic        reset;
  logic [9:0]  rx_raw;
  logic        rx_raw_valid;
  logic [9:0]  cg_out;
  logic        cg_valid;
  logic        cg_invalid;
  logic        comma_det;
  logic        rx_even;
  logic        sync_status;
  logic [3:0]  align_offset;
`ifdef PCS_SYNC_STATS_EN
  logic [15:0] sync_loss_cnt;
`endif

  always #5 clk = ~clk;

  pcs_sync_ctrl #(
    .COMMAS_TO_SYNC (C2S),
    .ERRS_TO_LOSE   (E2L),
    .GOOD_TO_RECOVER(G2R)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .rx_raw      (rx_raw),
    .rx_raw_valid(rx_raw_valid),
    .cg_out      (cg_out),
    .cg_valid    (cg_valid),
    .cg_invalid  (cg_invalid),
    .comma_det   (comma_det),
    .rx_even     (rx_even),
    .sync_status (sync_status),
    .align_offset(align_offset)
`ifdef PCS_SYNC_STATS_EN
    ,
    .sync_loss_cnt(sync_loss_cnt)
`endif
  );

  // ---------------- scoreboard ----------------
  typedef struct packed {
    logic [15:0] loss;
    logic [9:0]  cg;
    logic        comma;
    logic        even;
    logic [3:0]  off;
    logic        sync;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, req, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // phase: 0 hunting, 1 counting commas, 2 in sync
  int         m_phase, m_ccnt, m_err, m_good, m_off, m_loss;
  bit         m_even, m_shown;
  logic [9:0] m_prev, m_cg;

  function automatic bit comma_of(input logic [9:0] g);
    return (g[9:3] == 7'b0011111) || (g[9:3] == 7'b1100000);
  endfunction

  task automatic model_reset();
    m_phase = 0; m_ccnt = 0; m_err = 0; m_good = 0; m_off = 0; m_loss = 0;
    m_even = 1'b0; m_shown = 1'b0; m_prev = '0; m_cg = '0;
  endtask

  // One clock of the receiver: align the incoming beat (if any), judge the
  // group currently on display (if any), then queue the newly aligned group.
  task automatic model_cycle(input bit v, input logic [9:0] raw, input bit inv);
    logic [19:0] w;
    logic [19:0] t;
    logic [9:0]  cg;
    int          off;
    bit          found, cm, bd;
    exp_t        e;
    off = m_off;
    cg  = '0;
    if (v) begin
      w = {m_prev, raw};
      found = 1'b0;
      if (m_phase == 0) begin
        for (int k = 0; k < 10; k++) begin
          t = w >> (10 - k);
          if (!found && comma_of(t[9:0])) begin
            found = 1'b1;
            off = k;
          end
        end
      end
      t  = w >> (10 - off);
      cg = t[9:0];
    end
    if (m_shown) begin
      cm = comma_of(m_cg);
      bd = inv || (cm && !m_even);
      case (m_phase)
        0: if (cm && !inv) begin
             m_ccnt = 1;
             if (C2S == 1) begin m_phase = 2; m_err = 0; m_good = 0; end
             else m_phase = 1;
           end
        1: if (bd) m_phase = 0;
           else if (cm) begin
             m_ccnt++;
             if (m_ccnt >= C2S) begin m_phase = 2; m_err = 0; m_good = 0; end
           end
        default: if (bd) begin
             m_err++;
             m_good = 0;
             if (m_err >= E2L) begin
               m_phase = 0;
               if (m_loss < 65535) m_loss++;
             end
           end else if (m_err > 0) begin
             m_good++;
             if (m_good >= G2R) begin m_err--; m_good = 0; end
           end
      endcase
      m_even = cm ? 1'b0 : !m_even;
    end
    if (v) begin
      e.loss  = 16'(m_loss);
      e.cg    = cg;
      e.comma = comma_of(cg);
      e.even  = m_even;
      e.off   = 4'(off);
      e.sync  = (m_phase == 2);
      exp_q.push_back(e);
      m_prev = raw;
      m_off  = off;
      m_cg   = cg;
    end
    m_shown = v;
  endtask

  // ---------------- stimulus source ----------------
  bit         bq[$];        // serial bit stream, first bit at the front
  logic [9:0] grp_q[$];     // explicit groups sent before the idle pattern
  bit         plan_q[$];    // explicit cg_invalid flags for displayed groups
  bit         pat_k;
  int         noise_pct, dbl_pct;

  task automatic set_stream(input int shift);
    bq.delete();
    grp_q.delete();
    pat_k = 1'b1;
    for (int i = 0; i < shift; i++) bq.push_back(1'($urandom_range(1)));
  endtask

  function automatic logic [9:0] next_group();
    logic [9:0] g;
    if (grp_q.size() > 0) return grp_q.pop_front();
    if ($urandom_range(99) < dbl_pct) return K285;
    g = pat_k ? K285 : D162;
    pat_k = !pat_k;
    if ($urandom_range(99) < noise_pct) g = 10'($urandom);
    return g;
  endfunction

  task automatic next_raw(output logic [9:0] raw);
    logic [9:0] g;
    while (bq.size() < 10) begin
      g = next_group();
      for (int i = 9; i >= 0; i--) bq.push_back(g[i]);
    end
    for (int i = 9; i >= 0; i--) raw[i] = bq.pop_front();
  endtask

  // ---------------- driver tasks ----------------
  task automatic cycle(input bit v, input int inv_pct);
    logic [9:0] raw;
    bit         inv;
    @(negedge clk);
    if (v) next_raw(raw);
    else raw = 10'($urandom);
    if (m_shown) begin
      if (plan_q.size() > 0) inv = plan_q.pop_front();
      else inv = ($urandom_range(99) < inv_pct);
    end else begin
      inv = 1'($urandom_range(1));
    end
    rx_raw_valid = v;
    rx_raw       = raw;
    cg_invalid   = inv;
    model_cycle(v, raw, inv);
  endtask

  task automatic run(input int n, input int gap_pct, input int inv_pct);
    for (int i = 0; i < n; i++) cycle($urandom_range(99) >= gap_pct, inv_pct);
  endtask

  task automatic check_reset_outputs();
    check("rst_cg_out", 32'(cg_out), 32'd0);
    check("rst_cg_valid", 32'(cg_valid), 32'd0);
    check("rst_comma_det", 32'(comma_det), 32'd0);
    check("rst_rx_even", 32'(rx_even), 32'd0);
    check("rst_sync_status", 32'(sync_status), 32'd0);
    check("rst_align_offset", 32'(align_offset), 32'd0);
`ifdef PCS_SYNC_STATS_EN
    check("rst_sync_loss_cnt", 32'(sync_loss_cnt), 32'd0);
`endif
  endtask

  // Asynchronous reset placed away from both clock edges.
  task automatic do_reset();
    @(negedge clk);
    #2;
    reset        = 1'b1;
    rx_raw_valid = 1'b0;
    #1;
    check_reset_outputs();
    model_reset();
    exp_q.delete();
    plan_q.delete();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // ---------------- monitor ----------------
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (!reset && cg_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_cg_valid", 32'(cg_valid), 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("cg_out", 32'(cg_out), 32'(e.cg));
        check("comma_det", 32'(comma_det), 32'(e.comma));
        check("rx_even", 32'(rx_even), 32'(e.even));
        check("align_offset", 32'(align_offset), 32'(e.off));
        check("sync_status", 32'(sync_status), 32'(e.sync));
`ifdef PCS_SYNC_STATS_EN
        check("sync_loss_cnt", 32'(sync_loss_cnt), 32'(e.loss));
`endif
      end
    end
  end

  // ---------------- test sequence ----------------
  initial begin
    reset        = 1'b1;
    rx_raw       = '0;
    rx_raw_valid = 1'b0;
    cg_invalid   = 1'b0;
    noise_pct    = 0;
    dbl_pct      = 0;
    model_reset();
    set_stream(0);
    repeat (2) @(negedge clk);
    check_reset_outputs();
    reset = 1'b0;

    // Clean K28.5/D16.2 at offset 0, then an error burst pattern in sync.
    run(30, 0, 0);
    repeat (3) plan_q.push_back(1'b1);
    repeat (8) plan_q.push_back(1'b0);
    repeat (4) plan_q.push_back(1'b1);
    run(30, 0, 0);
    // Four straight invalids from a fresh sync.
    repeat (4) plan_q.push_back(1'b1);
    run(30, 0, 0);

    // Same stream shifted by three bits.
    do_reset();
    set_stream(3);
    run(30, 0, 0);

    // Back-to-back commas while counting: second lands on an odd slot.
    do_reset();
    set_stream(0);
    grp_q = '{K285, D162, K285, K285, D162, K285, D162};
    run(30, 0, 0);

    // Sync with gaps, then reset mid-stream and re-acquire.
    do_reset();
    set_stream(7);
    run(40, 25, 0);
    do_reset();
    set_stream(7);
    run(40, 25, 0);

    // Randomized rounds: offsets, gaps, decoder errors, noise and double commas.
    for (int r = 0; r < 10; r++) begin
      if ($urandom_range(1) == 1) do_reset();
      set_stream($urandom_range(9));
      noise_pct = $urandom_range(4);
      dbl_pct   = $urandom_range(3);
      run(250, $urandom_range(30), $urandom_range(20));
    end

    noise_pct = 0;
    dbl_pct   = 0;
    run(5, 100, 0);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
